// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
// The controller, its bus interface and its arbiter all import this package.
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intStateT;

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_CH_LSB    = 4;
  localparam int CTRL_GIE_BIT   = 0;

  // A single channel still needs a one-bit id.
  function automatic int chWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Register bus and pipeline handshake between the interrupt controller and the core.
// The master is the core side; the slave is int_ctrl.
interface int_ctrl_if #(parameter int NUM_CH = 4) ();
  import int_ctrl_pkg::*;

  localparam int CH_W = chWidth(NUM_CH);

  logic            regWrEn;
  logic [1:0]      regAddr;
  logic [15:0]     regWrData;
  logic [15:0]     regRdData;
  logic            intReq;
  logic [31:0]     intVector;
  logic [CH_W-1:0] intId;
  logic            intAck;
  logic            intDone;

  modport master (
    output regWrEn, regAddr, regWrData, intAck, intDone,
    input  regRdData, intReq, intVector, intId
  );

  modport slave (
    input  regWrEn, regAddr, regWrData, intAck, intDone,
    output regRdData, intReq, intVector, intId
  );

endinterface

// File: rtl/int_priority_arbiter.sv
// Fixed-priority arbiter: the lowest-numbered eligible channel wins.
module int_priority_arbiter
  import int_ctrl_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]           eligible,
  output logic [chWidth(NUM_CH)-1:0]  winner,
  output logic                        anyValid
);

  localparam int CH_W = chWidth(NUM_CH);

  always_comb begin
    winner   = '0;
    anyValid = |eligible;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eligible[i]) winner = CH_W'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: pending capture, fixed-priority arbitration and the
// request/acknowledge/return handshake towards the pipeline.
//   state   | meaning
//   IDLE    | waiting for an eligible channel
//   REQ     | intReq held for the winner until intAck
//   SERVICE | handler running, waiting for intDone
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int              NUM_CH     = 4,
  parameter logic [NUM_CH-1:0] EDGE_MODE = '1,
  parameter logic [31:0]     VEC_BASE   = 32'h0000_0000,
  parameter logic [31:0]     VEC_STRIDE = 32'd2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] irq,
  int_ctrl_if.slave         bus
);

  localparam int CH_W = chWidth(NUM_CH);

  intStateT          state;
  logic [CH_W-1:0]   activeCh;
  logic              intReqR;
  logic [31:0]       intVectorR;
  logic [CH_W-1:0]   intIdR;

  logic [NUM_CH-1:0] irqQ;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] mask;
  logic              gie;

  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] setVec;
  logic [NUM_CH-1:0] clrVec;
  logic [CH_W-1:0]   winner;
  logic              anyValid;
  logic              ackNow;
  logic [15:0]       rdData;

  wire unusedBits = &{1'b0, bus.regWrData};

  assign ackNow   = (state == REQ) && bus.intAck;
  assign setVec   = irq & ~irqQ & EDGE_MODE;
  assign eligible = pending & mask & {NUM_CH{gie}};

  // Software and acknowledge clears; a same-cycle set event overrides both below.
  always_comb begin
    clrVec = '0;
    if (bus.regWrEn && bus.regAddr == ADDR_PENDING) clrVec = bus.regWrData[NUM_CH-1:0];
    if (ackNow) clrVec[activeCh] = 1'b1;
  end

  int_priority_arbiter #(.NUM_CH(NUM_CH)) uArb (
    .eligible (eligible),
    .winner   (winner),
    .anyValid (anyValid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irqQ    <= '0;
      pending <= '0;
      mask    <= '0;
      gie     <= 1'b0;
    end else begin
      irqQ    <= irq;
      pending <= (EDGE_MODE & ((pending & ~clrVec) | setVec)) | (~EDGE_MODE & irq);
      if (bus.regWrEn && bus.regAddr == ADDR_MASK) mask <= bus.regWrData[NUM_CH-1:0];
      if (bus.regWrEn && bus.regAddr == ADDR_CTRL) gie <= bus.regWrData[CTRL_GIE_BIT];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      activeCh   <= '0;
      intReqR    <= 1'b0;
      intVectorR <= '0;
      intIdR     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (anyValid) begin
            activeCh   <= winner;
            intIdR     <= winner;
            intVectorR <= VEC_BASE + 32'(winner) * VEC_STRIDE;
            intReqR    <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (bus.intAck) begin
            intReqR <= 1'b0;
            state   <= SERVICE;
          end
        end
        SERVICE: begin
          if (bus.intDone) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdData = '0;
    case (bus.regAddr)
      ADDR_MASK:    rdData = 16'(mask);
      ADDR_PENDING: rdData = 16'(pending);
      ADDR_STATUS: begin
        rdData[STAT_STATE_LSB +: 2] = state;
        rdData[STAT_CH_LSB +: 4]    = 4'(activeCh);
      end
      ADDR_CTRL:    rdData[CTRL_GIE_BIT] = gie;
      default:      rdData = '0;
    endcase
  end

  assign bus.regRdData = rdData;
  assign bus.intReq    = intReqR;
  assign bus.intVector = intVectorR;
  assign bus.intId     = intIdR;

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4, number of interrupt channels; legal range 1..16.
REQ-002 Parameter EDGE_MODE [NUM_CH-1:0], default all ones; bit i=1 means channel i is edge-triggered, 0 means level-triggered.
REQ-003 Parameter VEC_BASE [31:0], default 32'h0000_0000, address of the channel-0 handler.
REQ-004 Parameter VEC_STRIDE [31:0], default 32'd2, address spacing between consecutive channel handlers.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port irq, input, NUM_CH bits: raw interrupt lines, synchronous to clk.
REQ-008 Port regWrEn, input, 1 bit: register write strobe.
REQ-009 Port regAddr, input, 2 bits: register select; 0 MASK, 1 PENDING, 2 STATUS, 3 CTRL.
REQ-010 Port regWrData, input, 16 bits: register write data.
REQ-011 Port regRdData, output, 16 bits: combinational read of the selected register; unused bits read 0.
REQ-012 Port intReq, output, 1 bit: registered interrupt request to the pipeline.
REQ-013 Port intVector, output, 32 bits: registered handler address; valid while intReq=1.
REQ-014 Port intId, output, CH_W bits: registered winning channel, where CH_W = max(1, clog2(NUM_CH)).
REQ-015 Port intAck, input, 1 bit: the pipeline has accepted the request and entered the handler.
REQ-016 Port intDone, input, 1 bit: the handler has returned (RTI retired).

Function
REQ-017 States: IDLE, REQ, SERVICE.
REQ-018 Edge channels: a pending bit sets one cycle after irq is sampled 0 then 1; it stays set until cleared.
REQ-019 Level channels: the pending bit equals irq registered by one cycle; ack and write-1-to-clear have no effect on it.
REQ-020 A channel is eligible when pending & MASK & CTRL.GIE; the eligible channel with the lowest index wins.
REQ-021 IDLE: if any channel is eligible, register activeCh, intId and intVector = VEC_BASE + activeCh*VEC_STRIDE (32-bit wrap), set intReq=1, and go to REQ.
REQ-022 REQ: intReq, intId and intVector hold stable until intAck; mask, GIE or pending changes do not withdraw or re-arbitrate the request.
REQ-023 REQ with intAck: clear intReq, clear activeCh's edge pending bit, go to SERVICE; intDone in the same cycle is ignored.
REQ-024 SERVICE: intDone returns the block to IDLE; no preemption or nesting occurs.
REQ-025 intAck outside REQ is ignored; intDone outside SERVICE is ignored.
REQ-026 Latency: an edge irq rising with the block in IDLE gives intReq=1 two clock edges later; after intDone, a new intReq appears no earlier than one cycle after entering IDLE.
REQ-027 PENDING write: 1-bits clear edge pending bits; a set event in the same cycle wins over a software or ack clear.
REQ-028 MASK: read/write, bits [NUM_CH-1:0].
REQ-029 CTRL: bit 0 is GIE, read/write.
REQ-030 STATUS: read-only; bits [1:0] state (0 IDLE, 1 REQ, 2 SERVICE), bits [7:4] activeCh.
REQ-031 A level channel still asserted after intDone is requested again.

Reset
REQ-032 While reset=0: state IDLE; MASK, GIE, pending and sampled-irq registers 0; intReq 0; intVector 0; intId 0.
REQ-033 Reset asserted mid-REQ or mid-SERVICE drops intReq immediately (asynchronously).
REQ-034 After reset release, no request is raised until software sets both MASK and GIE.

Structure
REQ-035 Package int_ctrl_pkg holds the state enum, register address constants and STATUS field positions.
REQ-036 Sub-module int_priority_arbiter, parametrised by NUM_CH, is purely combinational: eligible vector in, winner index and any-valid flag out.

Verification
REQ-037 NUM_CH=4, MASK=4'hF, GIE=1, irq[2] rises at cycle 0 -> intReq=1 at edge 2, intId=2, intVector=32'h4; intAck -> intReq=0, pending[2]=0, STATUS state=2.
REQ-038 irq[3] and irq[1] rise in the same cycle -> channel 1 served first; after intAck and intDone, channel 3 is requested with intVector=32'h6.
REQ-039 Level channel 0 (EDGE_MODE=4'b1110) held high through intAck and intDone -> intReq reasserts after one cycle in IDLE; drop irq[0] -> no further request.
REQ-040 Software writes PENDING=4'h2 in the same cycle irq[1] makes a new rising edge -> pending[1] remains 1.
REQ-041 In REQ, clear MASK and GIE -> intReq and intVector stay held until intAck; reset pulsed in SERVICE -> all outputs 0, state IDLE.
